// File: rtl/avalon_mm_arbiter.sv
// Two-requester Avalon-MM arbiter in front of one EMIF port.
// Write bursts hold the grant; a tag FIFO routes read returns.
module avalon_mm_arbiter #(
  parameter int DATA_WIDTH  = 512,
  parameter int ADDR_WIDTH  = 28,
  parameter int BURST_WIDTH = 7,
  parameter int TAG_DEPTH   = 8
) (
  input  logic                   clk,
  input  logic                   reset,

  input  logic [ADDR_WIDTH-1:0]  r0_address,
  input  logic [BURST_WIDTH-1:0] r0_burstcount,
  input  logic                   r0_read,
  input  logic                   r0_write,
  input  logic [DATA_WIDTH-1:0]  r0_writedata,
  output logic                   r0_waitrequest,
  output logic                   r0_readdatavalid,
  output logic [DATA_WIDTH-1:0]  r0_readdata,

  input  logic [ADDR_WIDTH-1:0]  r1_address,
  input  logic [BURST_WIDTH-1:0] r1_burstcount,
  input  logic                   r1_read,
  input  logic                   r1_write,
  input  logic [DATA_WIDTH-1:0]  r1_writedata,
  output logic                   r1_waitrequest,
  output logic                   r1_readdatavalid,
  output logic [DATA_WIDTH-1:0]  r1_readdata,

  output logic [ADDR_WIDTH-1:0]  address,
  output logic [BURST_WIDTH-1:0] burstcount,
  output logic                   read,
  output logic                   write,
  output logic [DATA_WIDTH-1:0]  writedata,
  input  logic                   waitrequest,
  input  logic                   readdatavalid,
  input  logic [DATA_WIDTH-1:0]  readdata,

  output logic                   err_orphan
);

  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(TAG_DEPTH);
  localparam logic [BURST_WIDTH-1:0] ONE_BC = BURST_WIDTH'(1);

  typedef enum logic {
    ST_OPEN,
    ST_LOCK
  } lock_state_t;

  lock_state_t            r_state;
  logic                   r_lock_id;
  logic [BURST_WIDTH-1:0] r_beats;
  logic                   r_last;

  logic                   r_tag_id [TAG_DEPTH];
  logic [BURST_WIDTH-1:0] r_tag_bc [TAG_DEPTH];
  logic [PW-1:0]          r_wptr;
  logic [PW-1:0]          r_rptr;
  logic [CW-1:0]          r_count;
  logic [BURST_WIDTH-1:0] r_rbeat;
  logic                   r_orphan;

  logic                   w_req0;
  logic                   w_req1;
  logic                   w_gnt_v;
  logic                   w_gnt_id;
  logic [ADDR_WIDTH-1:0]  w_sel_addr;
  logic [BURST_WIDTH-1:0] w_sel_bc;
  logic [DATA_WIDTH-1:0]  w_sel_wd;
  logic                   w_sel_rd;
  logic                   w_sel_wr;
  logic                   w_is_rd;
  logic                   w_is_wr;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_blk;
  logic                   w_wait_g;
  logic                   w_acc;
  logic                   w_push;
  logic                   w_wr_acc;
  logic [BURST_WIDTH-1:0] w_bc_eff;
  logic                   w_head_id;
  logic [BURST_WIDTH-1:0] w_head_bc;
  logic [BURST_WIDTH-1:0] w_rbeat_nxt;
  logic                   w_beat;
  logic                   w_pop;

  assign w_req0 = r0_read | r0_write;
  assign w_req1 = r1_read | r1_write;

  // While locked only the burst owner may be granted.
  always_comb begin
    w_gnt_v  = 1'b0;
    w_gnt_id = 1'b0;
    if (r_state == ST_LOCK) begin
      w_gnt_id = r_lock_id;
      w_gnt_v  = r_lock_id ? w_req1 : w_req0;
    end else begin
      unique case (1'b1)
        (w_req0 & w_req1): begin
          w_gnt_v  = 1'b1;
          w_gnt_id = ~r_last;
        end
        (w_req0 & ~w_req1): begin
          w_gnt_v  = 1'b1;
          w_gnt_id = 1'b0;
        end
        (~w_req0 & w_req1): begin
          w_gnt_v  = 1'b1;
          w_gnt_id = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign w_sel_addr = w_gnt_id ? r1_address    : r0_address;
  assign w_sel_bc   = w_gnt_id ? r1_burstcount : r0_burstcount;
  assign w_sel_wd   = w_gnt_id ? r1_writedata  : r0_writedata;
  assign w_sel_rd   = w_gnt_id ? r1_read       : r0_read;
  assign w_sel_wr   = w_gnt_id ? r1_write      : r0_write;

  assign w_is_wr  = w_gnt_v & w_sel_wr;
  assign w_is_rd  = w_gnt_v & w_sel_rd & ~w_sel_wr;
  assign w_full   = (r_count == FULL_CNT);
  assign w_empty  = (r_count == '0);
  assign w_blk    = w_is_rd & w_full;
  assign w_wait_g = waitrequest | w_blk;
  assign w_acc    = w_gnt_v & ~waitrequest & ~w_blk;
  assign w_push   = w_acc & w_is_rd;
  assign w_wr_acc = w_acc & w_is_wr;
  assign w_bc_eff = (w_sel_bc == '0) ? ONE_BC : w_sel_bc;

  assign read       = w_is_rd & ~w_full;
  assign write      = w_is_wr;
  assign address    = w_gnt_v ? w_sel_addr : '0;
  assign burstcount = w_gnt_v ? w_sel_bc   : '0;
  assign writedata  = w_gnt_v ? w_sel_wd   : '0;

  assign r0_waitrequest = (w_gnt_v & ~w_gnt_id) ? w_wait_g : 1'b1;
  assign r1_waitrequest = (w_gnt_v &  w_gnt_id) ? w_wait_g : 1'b1;

  assign w_head_id   = r_tag_id[r_rptr];
  assign w_head_bc   = r_tag_bc[r_rptr];
  assign w_rbeat_nxt = r_rbeat + ONE_BC;
  assign w_beat      = readdatavalid & ~w_empty;
  assign w_pop       = w_beat & (w_rbeat_nxt == w_head_bc);

  assign r0_readdatavalid = w_beat & ~w_head_id;
  assign r1_readdatavalid = w_beat &  w_head_id;
  assign r0_readdata      = readdata;
  assign r1_readdata      = readdata;
  assign err_orphan       = r_orphan;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_OPEN;
      r_lock_id <= 1'b0;
      r_beats   <= '0;
      r_last    <= 1'b1;
    end else begin
      if (w_acc) r_last <= w_gnt_id;
      unique case (r_state)
        ST_OPEN: begin
          if (w_wr_acc && (w_bc_eff > ONE_BC)) begin
            r_state   <= ST_LOCK;
            r_lock_id <= w_gnt_id;
            r_beats   <= w_bc_eff - ONE_BC;
          end
        end
        ST_LOCK: begin
          if (w_wr_acc) begin
            r_beats <= r_beats - ONE_BC;
            if (r_beats == ONE_BC) r_state <= ST_OPEN;
          end
        end
        default: r_state <= ST_OPEN;
      endcase
    end
  end

  // Tag storage needs no reset; occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_tag_id[r_wptr] <= w_gnt_id;
      r_tag_bc[r_wptr] <= w_bc_eff;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_rbeat  <= '0;
      r_orphan <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      if (w_beat) r_rbeat <= w_pop ? '0 : w_rbeat_nxt;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (readdatavalid && w_empty) r_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_avalon_mm_arbiter.sv
// Bench for avalon_mm_arbiter: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_avalon_mm_arbiter;

  localparam int DW = 32;
  localparam int AW = 28;
  localparam int BW = 7;
  localparam int TD = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [AW-1:0] r0_address, r1_address;
  logic [BW-1:0] r0_burstcount, r1_burstcount;
  logic          r0_read, r1_read, r0_write, r1_write;
  logic [DW-1:0] r0_writedata, r1_writedata;
  logic          r0_waitrequest, r1_waitrequest;
  logic          r0_readdatavalid, r1_readdatavalid;
  logic [DW-1:0] r0_readdata, r1_readdata;
  logic [AW-1:0] address;
  logic [BW-1:0] burstcount;
  logic          read, write;
  logic [DW-1:0] writedata;
  logic          waitrequest, readdatavalid;
  logic [DW-1:0] readdata;
  logic          err_orphan;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  avalon_mm_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .BURST_WIDTH(BW), .TAG_DEPTH(TD)
  ) dut (
    .clk(clk), .reset(reset),
    .r0_address(r0_address), .r0_burstcount(r0_burstcount),
    .r0_read(r0_read), .r0_write(r0_write),
    .r0_writedata(r0_writedata), .r0_waitrequest(r0_waitrequest),
    .r0_readdatavalid(r0_readdatavalid), .r0_readdata(r0_readdata),
    .r1_address(r1_address), .r1_burstcount(r1_burstcount),
    .r1_read(r1_read), .r1_write(r1_write),
    .r1_writedata(r1_writedata), .r1_waitrequest(r1_waitrequest),
    .r1_readdatavalid(r1_readdatavalid), .r1_readdata(r1_readdata),
    .address(address), .burstcount(burstcount),
    .read(read), .write(write), .writedata(writedata),
    .waitrequest(waitrequest), .readdatavalid(readdatavalid),
    .readdata(readdata), .err_orphan(err_orphan)
  );

  task automatic idle_inputs();
    r0_address = '0; r0_burstcount = '0; r0_read = 0; r0_write = 0;
    r0_writedata = '0;
    r1_address = '0; r1_burstcount = '0; r1_read = 0; r1_write = 0;
    r1_writedata = '0;
    waitrequest = 0; readdatavalid = 0; readdata = '0;
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    idle_inputs();
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1;
    idle_inputs();
    r0_read = 1; r0_address = 28'h0ABCDE; r0_burstcount = 2;
    readdatavalid = 1;
    next();
    #1;
    tests_run++;
    if (read !== 1'b1 || write !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_cmd: read=%b write=%b want 1 0", read, write);
    end
    tests_run++;
    if (address !== 28'h0ABCDE) begin
      tests_failed++;
      $display("FAIL reset_addr: got %h want 0abcde", address);
    end
    tests_run++;
    if ({r1_readdatavalid, r0_readdatavalid} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_rdv: got %b%b want 00",
               r1_readdatavalid, r0_readdatavalid);
    end
    tests_run++;
    if (err_orphan !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_orphan: got %b want 0", err_orphan);
    end
    next();
    reset = 0;
    idle_inputs();
    #1;
    tests_run++;
    if (read !== 1'b0 || address !== '0 || burstcount !== '0) begin
      tests_failed++;
      $display("FAIL reset_idle: read=%b addr=%h bc=%0d want 0 0 0",
               read, address, burstcount);
    end
    tests_run++;
    if ({r1_waitrequest, r0_waitrequest} !== 2'b11) begin
      tests_failed++;
      $display("FAIL reset_wait: got %b%b want 11",
               r1_waitrequest, r0_waitrequest);
    end
  endtask

  task automatic test_tie();
    logic [AW-1:0] ea;
    do_reset();
    r0_read = 1; r0_burstcount = 4; r0_address = 28'h100;
    r1_read = 1; r1_burstcount = 4; r1_address = 28'h200;
    for (int k = 0; k < 4; k++) begin
      #1;
      ea = (k % 2 == 0) ? 28'h100 : 28'h200;
      tests_run++;
      if (address !== ea || read !== 1'b1 || burstcount !== 7'd4) begin
        tests_failed++;
        $display("FAIL tie_cyc%0d: addr=%h rd=%b bc=%0d want %h 1 4",
                 k, address, read, burstcount, ea);
      end
      tests_run++;
      if (r0_waitrequest !== (k % 2 == 1) ||
          r1_waitrequest !== (k % 2 == 0)) begin
        tests_failed++;
        $display("FAIL tie_wait%0d: got r0=%b r1=%b", k,
                 r0_waitrequest, r1_waitrequest);
      end
      next();
    end
    idle_inputs();
  endtask

  task automatic test_write_lock();
    do_reset();
    r1_write = 1; r1_burstcount = 3; r1_address = 28'h300;
    r1_writedata = 32'hD0D0_0000;
    #1;
    tests_run++;
    if (write !== 1'b1 || writedata !== 32'hD0D0_0000 ||
        r1_waitrequest !== 1'b0) begin
      tests_failed++;
      $display("FAIL lock_beat1: wr=%b wd=%h w1=%b want 1 d0d00000 0",
               write, writedata, r1_waitrequest);
    end
    next();
    r0_read = 1; r0_burstcount = 1; r0_address = 28'h10;
    r1_writedata = 32'hD1D1_0001;
    waitrequest = 1;
    for (int k = 0; k < 2; k++) begin
      #1;
      tests_run++;
      if (r0_waitrequest !== 1'b1 || r1_waitrequest !== 1'b1 ||
          address !== 28'h300 || read !== 1'b0) begin
        tests_failed++;
        $display("FAIL lock_stall%0d: w0=%b w1=%b addr=%h rd=%b", k,
                 r0_waitrequest, r1_waitrequest, address, read);
      end
      next();
    end
    waitrequest = 0;
    #1;
    tests_run++;
    if (write !== 1'b1 || writedata !== 32'hD1D1_0001 ||
        r0_waitrequest !== 1'b1) begin
      tests_failed++;
      $display("FAIL lock_beat2: wr=%b wd=%h w0=%b want 1 d1d10001 1",
               write, writedata, r0_waitrequest);
    end
    next();
    r1_write = 0;
    #1;
    tests_run++;
    if (write !== 1'b0 || read !== 1'b0 || r0_waitrequest !== 1'b1) begin
      tests_failed++;
      $display("FAIL lock_gap: wr=%b rd=%b w0=%b want 0 0 1",
               write, read, r0_waitrequest);
    end
    next();
    r1_write = 1; r1_writedata = 32'hD2D2_0002;
    #1;
    tests_run++;
    if (write !== 1'b1 || writedata !== 32'hD2D2_0002 ||
        r0_waitrequest !== 1'b1) begin
      tests_failed++;
      $display("FAIL lock_beat3: wr=%b wd=%h w0=%b want 1 d2d20002 1",
               write, writedata, r0_waitrequest);
    end
    next();
    r1_write = 0;
    #1;
    tests_run++;
    if (read !== 1'b1 || address !== 28'h10 || r0_waitrequest !== 1'b0) begin
      tests_failed++;
      $display("FAIL lock_release: rd=%b addr=%h w0=%b want 1 10 0",
               read, address, r0_waitrequest);
    end
    next();
    idle_inputs();
  endtask

  task automatic test_routing();
    logic [1:0] ev;
    do_reset();
    r0_read = 1; r0_burstcount = 2; r0_address = 28'h40;
    #1;
    tests_run++;
    if (r0_waitrequest !== 1'b0 || read !== 1'b1) begin
      tests_failed++;
      $display("FAIL route_r0cmd: w0=%b rd=%b want 0 1", r0_waitrequest, read);
    end
    next();
    r0_read = 0;
    r1_read = 1; r1_burstcount = 3; r1_address = 28'h80;
    #1;
    tests_run++;
    if (r1_waitrequest !== 1'b0 || read !== 1'b1) begin
      tests_failed++;
      $display("FAIL route_r1cmd: w1=%b rd=%b want 0 1", r1_waitrequest, read);
    end
    next();
    idle_inputs();
    for (int b = 0; b < 5; b++) begin
      readdatavalid = 1;
      readdata = $urandom;
      #1;
      ev = (b < 2) ? 2'b01 : 2'b10;
      tests_run++;
      if ({r1_readdatavalid, r0_readdatavalid} !== ev ||
          r0_readdata !== readdata || r1_readdata !== readdata) begin
        tests_failed++;
        $display("FAIL route_beat%0d: rdv=%b%b want %b", b + 1,
                 r1_readdatavalid, r0_readdatavalid, ev);
      end
      next();
    end
    readdatavalid = 1;
    #1;
    tests_run++;
    if ({r1_readdatavalid, r0_readdatavalid} !== 2'b00 ||
        err_orphan !== 1'b0) begin
      tests_failed++;
      $display("FAIL route_extra: rdv=%b%b orphan=%b want 00 0",
               r1_readdatavalid, r0_readdatavalid, err_orphan);
    end
    next();
    readdatavalid = 0;
    #1;
    tests_run++;
    if (err_orphan !== 1'b1) begin
      tests_failed++;
      $display("FAIL route_empty: orphan=%b want 1", err_orphan);
    end
    idle_inputs();
  endtask

  task automatic test_full();
    do_reset();
    for (int k = 0; k < TD; k++) begin
      r0_read = 1; r0_burstcount = 1; r0_address = AW'(k);
      #1;
      tests_run++;
      if (read !== 1'b1 || r0_waitrequest !== 1'b0) begin
        tests_failed++;
        $display("FAIL full_fill%0d: rd=%b w0=%b want 1 0", k,
                 read, r0_waitrequest);
      end
      next();
    end
    r0_address = 28'h99;
    r1_write = 1; r1_burstcount = 1; r1_address = 28'h55;
    r1_writedata = 32'hCAFE_F00D;
    #1;
    tests_run++;
    if (write !== 1'b1 || read !== 1'b0 || writedata !== 32'hCAFE_F00D ||
        r0_waitrequest !== 1'b1 || r1_waitrequest !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_write: wr=%b rd=%b wd=%h w0=%b w1=%b",
               write, read, writedata, r0_waitrequest, r1_waitrequest);
    end
    next();
    r1_write = 0;
    #1;
    tests_run++;
    if (read !== 1'b0 || r0_waitrequest !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_block: rd=%b w0=%b want 0 1", read, r0_waitrequest);
    end
    next();
    readdatavalid = 1;
    #1;
    tests_run++;
    if (r0_readdatavalid !== 1'b1 || read !== 1'b0 ||
        r0_waitrequest !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_popcyc: rdv0=%b rd=%b w0=%b want 1 0 1",
               r0_readdatavalid, read, r0_waitrequest);
    end
    next();
    readdatavalid = 0;
    #1;
    tests_run++;
    if (read !== 1'b1 || address !== 28'h99 || r0_waitrequest !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_unblock: rd=%b addr=%h w0=%b want 1 99 0",
               read, address, r0_waitrequest);
    end
    next();
    idle_inputs();
  endtask

  task automatic test_orphan();
    do_reset();
    r0_read = 1; r0_burstcount = 1;
    next();
    r0_read = 0;
    r1_read = 1; r1_burstcount = 1;
    next();
    idle_inputs();
    reset = 1;
    next();
    reset = 0;
    readdatavalid = 1;
    #1;
    tests_run++;
    if ({r1_readdatavalid, r0_readdatavalid} !== 2'b00 ||
        err_orphan !== 1'b0) begin
      tests_failed++;
      $display("FAIL orphan_beat: rdv=%b%b orphan=%b want 00 0",
               r1_readdatavalid, r0_readdatavalid, err_orphan);
    end
    next();
    readdatavalid = 0;
    #1;
    tests_run++;
    if (err_orphan !== 1'b1) begin
      tests_failed++;
      $display("FAIL orphan_flag: got %b want 1", err_orphan);
    end
    idle_inputs();
  endtask

  typedef struct {
    bit id;
    int bc;
  } tag_t;

  task automatic test_random();
    tag_t q[$];
    tag_t t;
    int m_last, m_lock_id, m_left, m_rbeat;
    bit m_locked, m_orphan;
    bit rq[2], rd[2], wr[2];
    logic [AW-1:0] ad[2];
    logic [BW-1:0] bc[2];
    logic [DW-1:0] wd[2];
    int g, rd_pct, rdv_pct, eff;
    bit gv, full, blk;
    logic e_read, e_write, e_w0, e_w1;
    logic [AW-1:0] e_addr;
    logic [BW-1:0] e_bc;
    logic [DW-1:0] e_wd;
    logic [1:0] e_rdv;
    do_reset();
    m_last = 1; m_locked = 0; m_lock_id = 0; m_left = 0;
    m_rbeat = 0; m_orphan = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rdv_pct = ((cyc / 500) % 2 == 0) ? 50 : 12;
      rd_pct = ((cyc / 500) % 2 == 0) ? 40 : 70;
      reset = ($urandom_range(199) == 0);
      r0_read = ($urandom_range(99) < rd_pct);
      r1_read = ($urandom_range(99) < rd_pct);
      r0_write = ($urandom_range(99) < 25);
      r1_write = ($urandom_range(99) < 25);
      r0_burstcount = BW'($urandom_range(4));
      r1_burstcount = BW'($urandom_range(4));
      r0_address = AW'($urandom); r1_address = AW'($urandom);
      r0_writedata = $urandom; r1_writedata = $urandom;
      waitrequest = ($urandom_range(99) < 30);
      readdatavalid = ($urandom_range(99) < rdv_pct);
      readdata = $urandom;
      #1;
      rd[0] = r0_read & ~r0_write; wr[0] = r0_write;
      rd[1] = r1_read & ~r1_write; wr[1] = r1_write;
      rq[0] = r0_read | r0_write; rq[1] = r1_read | r1_write;
      ad[0] = r0_address; ad[1] = r1_address;
      bc[0] = r0_burstcount; bc[1] = r1_burstcount;
      wd[0] = r0_writedata; wd[1] = r1_writedata;
      gv = 1; g = 0;
      if (m_locked) begin g = m_lock_id; gv = rq[g]; end
      else if (rq[0] && rq[1]) g = 1 - m_last;
      else if (rq[0]) g = 0;
      else if (rq[1]) g = 1;
      else gv = 0;
      full = (q.size() == TD);
      blk = gv && rd[g] && full;
      e_read = gv && rd[g] && !full;
      e_write = gv && wr[g];
      e_addr = gv ? ad[g] : '0;
      e_bc = gv ? bc[g] : '0;
      e_wd = gv ? wd[g] : '0;
      e_w0 = (gv && g == 0) ? (waitrequest || blk) : 1'b1;
      e_w1 = (gv && g == 1) ? (waitrequest || blk) : 1'b1;
      e_rdv = 2'b00;
      if (readdatavalid && q.size() > 0) e_rdv[q[0].id] = 1'b1;
      tests_run++;
      if ({read, write, address, burstcount, writedata} !==
          {e_read, e_write, e_addr, e_bc, e_wd}) begin
        tests_failed++;
        $display("FAIL rnd_cmd c%0d: rd=%b wr=%b a=%h bc=%0d wd=%h want %b %b %h %0d %h",
                 cyc, read, write, address, burstcount, writedata,
                 e_read, e_write, e_addr, e_bc, e_wd);
      end
      tests_run++;
      if ({r1_waitrequest, r0_waitrequest} !== {e_w1, e_w0}) begin
        tests_failed++;
        $display("FAIL rnd_wait c%0d: got %b%b want %b%b", cyc,
                 r1_waitrequest, r0_waitrequest, e_w1, e_w0);
      end
      tests_run++;
      if ({r1_readdatavalid, r0_readdatavalid} !== e_rdv) begin
        tests_failed++;
        $display("FAIL rnd_rdv c%0d: got %b%b want %b", cyc,
                 r1_readdatavalid, r0_readdatavalid, e_rdv);
      end
      tests_run++;
      if (err_orphan !== m_orphan) begin
        tests_failed++;
        $display("FAIL rnd_orphan c%0d: got %b want %b", cyc,
                 err_orphan, m_orphan);
      end
      if (reset) begin
        q.delete();
        m_last = 1; m_locked = 0; m_left = 0;
        m_rbeat = 0; m_orphan = 0;
      end else begin
        if (readdatavalid) begin
          if (q.size() == 0) m_orphan = 1;
          else begin
            m_rbeat++;
            if (m_rbeat == q[0].bc) begin
              void'(q.pop_front());
              m_rbeat = 0;
            end
          end
        end
        if (gv && !waitrequest && !blk) begin
          m_last = g;
          eff = (bc[g] == 0) ? 1 : int'(bc[g]);
          if (rd[g]) begin
            t.id = g[0]; t.bc = eff;
            q.push_back(t);
          end
          if (wr[g]) begin
            if (m_locked) begin
              m_left--;
              if (m_left == 0) m_locked = 0;
            end else if (eff > 1) begin
              m_locked = 1; m_lock_id = g; m_left = eff - 1;
            end
          end
        end
      end
      next();
    end
    reset = 0;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_tie();
    test_write_lock();
    test_routing();
    test_full();
    test_orphan();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/avalon_mm_arbiter.md
AVALON_MM_ARBITER -- requirements
Module: avalon_mm_arbiter

Interface
REQ-001 Parameters (name, default, meaning): DATA_WIDTH, 512, word width; ADDR_WIDTH, 28, word address width; BURST_WIDTH, 7, burstcount width; TAG_DEPTH, 8, maximum outstanding read commands, power of two.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 rN_address, rN_burstcount, rN_read, rN_write, rN_writedata (N=0,1)  input  ADDR_WIDTH / BURST_WIDTH / 1 / 1 / DATA_WIDTH  requester N Avalon-MM command.
REQ-005 rN_waitrequest  output  1  stall to requester N.
REQ-006 rN_readdatavalid  output  1  read beat for requester N.
REQ-007 rN_readdata  output  DATA_WIDTH  copy of the downstream readdata.
REQ-008 address, burstcount, read, write, writedata  output  ADDR_WIDTH / BURST_WIDTH / 1 / 1 / DATA_WIDTH  downstream EMIF command.
REQ-009 waitrequest, readdatavalid  input  1 each; readdata  input  DATA_WIDTH  downstream response.
REQ-010 err_orphan  output  1  sticky flag: readdatavalid arrived while no read was outstanding.

Function
REQ-011 The command path is combinational, with zero-cycle latency: the downstream command equals the granted requester's command; when no requester is granted, read=write=0 and address, burstcount and writedata are 0.
REQ-012 A requester requests when its read or write is 1; a requester asserting both is treated as a write.
- REQ-013 Grant while unlocked:
  - If only one requester requests, that requester is granted.
  - If both request, the requester not equal to last_grant is granted.
  - last_grant resets to 1, so r0 wins the first tie.
REQ-014 Accept is defined as (granted request) and (downstream waitrequest=0); last_grant updates to the accepted requester on every accept.
REQ-015 The non-granted requester sees rN_waitrequest=1; the granted requester sees the downstream waitrequest, ORed with the tag-full block of REQ-019.
- REQ-016 Write-burst lock:
  - An accepted first write beat with burstcount B>1 locks the grant to that requester.
  - A beat counter is loaded with B-1 and decrements on each further accepted write beat.
  - The lock releases in the cycle the counter reaches 0.
  - The other requester is not granted while locked, even if the locked requester deasserts write.
REQ-017 Burstcount 0 is treated as 1 for lock and tag accounting; the downstream burstcount passes through unmodified.
- REQ-018 Tag FIFO:
  - Each accepted read pushes {requester id, burstcount} into a FIFO of depth TAG_DEPTH.
  - Reset value: empty, all pointers 0.
  - Pointers wrap modulo TAG_DEPTH.
  - The occupancy counter is log2(TAG_DEPTH)+1 bits wide.
REQ-019 When the FIFO holds TAG_DEPTH entries, a read from the granted requester is not forwarded (downstream read=0) and that requester sees waitrequest=1; a write is still forwarded.
- REQ-020 Response routing (combinational, zero latency):
  - On readdatavalid with the FIFO non-empty, the head id selects which rN_readdatavalid is 1.
  - A return-beat counter increments per beat.
  - The head entry is popped, and the counter cleared, on the beat that equals the head burstcount.
REQ-021 A push and a pop in the same cycle are both performed; occupancy is unchanged; when the FIFO is full, a pop in the same cycle does not unblock the read of REQ-019.
REQ-022 readdatavalid with the FIFO empty is dropped: both rN_readdatavalid stay 0 and err_orphan is set to 1.

Reset
REQ-023 With reset=1 on a clock edge, the following are cleared: lock, beat counter, FIFO, return-beat counter and err_orphan; last_grant is set to 1.
REQ-024 During and after reset the outputs follow the cleared state: downstream read=write=0 unless requests are present; both rN_readdatavalid=0.
REQ-025 A reset mid-operation abandons outstanding reads; late returning beats are treated as orphans per REQ-022.

Verification
REQ-026 Tie: r0 and r1 both read with burstcount 4, waitrequest=0 -> r0 accepted in cycle 0, r1 in cycle 1, then alternation continues.
REQ-027 Write lock: r1 writes burstcount 3, r0 reads concurrently, waitrequest pulsed high for 2 cycles mid-burst -> all 3 r1 beats pass before r0 is granted; r0_waitrequest=1 throughout the burst.
REQ-028 Routing: r0 reads burst 2, then r1 reads burst 3; 5 readdatavalid beats return -> r0_readdatavalid on beats 1-2, r1_readdatavalid on beats 3-5; FIFO empty afterwards.
REQ-029 Full: 8 burst-1 reads accepted with no returns -> the 9th read is blocked (read=0, requester waitrequest=1) while a concurrent write from the other requester is forwarded; one return beat -> the 9th read is accepted the following cycle.
REQ-030 Orphan/reset: 2 reads outstanding, reset pulsed for 1 cycle, then 1 readdatavalid -> both rN_readdatavalid=0 and err_orphan=1 in the following cycle.
